// File: rtl/muldiv_seq.sv
// Sequential integer multiply/divide unit for the RV32M/RV64M operation set.
// Multiplies with a shift-add loop over a 2*XLEN-bit product and divides with a
// restoring loop, one iteration per clock, followed by a one-cycle sign fix-up.
// Division by zero and signed overflow skip the loop and answer on the next cycle.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - request present
//   in_ready   - unit idle and able to accept (never during flush)
//   op         - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_val    - multiplicand / dividend
//   rs2_val    - multiplier / divisor
//   flush      - synchronous abort of any operation in flight
//   out_valid  - result available
//   out_ready  - consumer takes the result
//   result     - operation result
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic              neg_res;
    logic              neg_rem;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   res_pend;
    logic [XLEN-1:0]   res_last;

    logic              accept;
    logic              rs1_signed, rs2_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    // The pending result is only exposed while it is being offered, so an
    // aborted operation never disturbs the value last handed to the consumer.
    assign result    = (state == DONE) ? res_pend : res_last;

    // Request decode: both algorithms run on magnitudes, so the signs are
    // stripped here and reapplied in FIX. Divide-by-zero and the single signed
    // overflow case have fixed answers and bypass the iteration entirely.
    always_comb begin
        rs1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        rs2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg      = rs1_signed && rs1_val[XLEN-1];
        b_neg      = rs2_signed && rs2_val[XLEN-1];
        a_mag      = a_neg ? -rs1_val : rs1_val;
        b_mag      = b_neg ? -rs2_val : rs2_val;
        div_zero   = op[2] && (rs2_val == '0);
        div_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (rs1_val == MOST_NEG) && (&rs2_val);
        special    = div_zero || div_ovf;
        if (op[1]) begin
            special_val = div_zero ? rs1_val : '0;
        end else begin
            special_val = div_zero ? '1 : rs1_val;
        end
    end

    // One iteration of either loop. The accumulator holds {high, low}: for a
    // multiply the low half starts as the multiplier and is shifted out while
    // the product fills in from the top; for a divide the high half is the
    // partial remainder and quotient bits shift into the low half.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb};
        if (op_q[2]) begin
            if (div_diff[XLEN]) begin
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign correction and bit selection once the loop has finished.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quot_fix = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_val = acc[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = quot_fix;
            default:                      fix_val = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything, including a handshake.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = special ? DONE : CALC;
                CALC:    if (count == '0) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: operands are captured on acceptance, then iterated XLEN times
    // with the counter running down to zero on the last iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            acc      <= '0;
            opb      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            count    <= '0;
            res_pend <= '0;
            res_last <= '0;
        end else begin
            if (accept) begin
                op_q    <= op;
                acc     <= {{XLEN{1'b0}}, a_mag};
                opb     <= b_mag;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                count   <= CW'(XLEN - 1);
                if (special) begin
                    res_pend <= special_val;
                end
            end else if (state == CALC) begin
                acc   <= acc_step;
                count <= count - CW'(1);
            end
            if ((state == FIX) && !flush) begin
                res_pend <= fix_val;
            end
            if ((state == DONE) && out_ready && !flush) begin
                res_last <= res_pend;
            end
        end
    end

endmodule
